// File: rtl/ccd_readout_seq.sv
// ccd_readout_seq: parametrised CCD frame readout sequencer (54 MHz pixel clock domain).
// Sequence per frame: shutter pulse (thsub), exposure wait, transfer gates (rvt2/rvt3),
// then per output row an N-phase vertical shift (xvt) under hblank followed by H_PIXELS
// active pixel cycles. Supports programmable exposure and vertical binning.
// Ports:
//   clk, reset      pixel clock, asynchronous active-high reset
//   start           single-cycle frame request (ignored while busy)
//   vbin, exposure  binning factor (0 treated as 1) and exposure length, sampled on start
//   xvt             one-hot vertical shift clocks
//   rvt2, rvt3      readout transfer gates
//   thsub           substrate shutter pulse
//   hblank          1 = horizontal clocks stopped
//   pix_valid, pix_x, pix_y  active pixel flag and coordinates
//   busy, done      frame handshake
module ccd_readout_seq #(
  parameter int unsigned H_PIXELS   = 1024,
  parameter int unsigned H_BLANK    = 64,
  parameter int unsigned V_LINES    = 768,
  parameter int unsigned VT_WIDTH   = 8,
  parameter int unsigned NUM_PHASES = 4,
  parameter int unsigned CW         = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            vbin,
  input  logic [23:0]           exposure,
  output logic [NUM_PHASES-1:0] xvt,
  output logic                  rvt2,
  output logic                  rvt3,
  output logic                  thsub,
  output logic                  hblank,
  output logic                  pix_valid,
  output logic [CW-1:0]         pix_x,
  output logic [CW-1:0]         pix_y,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CNT_W    = 32;
  localparam int unsigned SHUT_LEN = NUM_PHASES * VT_WIDTH;
  localparam int unsigned XFER_LEN = 2 * VT_WIDTH;
  localparam int unsigned VT_W     = (VT_WIDTH > 1) ? $clog2(VT_WIDTH) : 1;
  localparam int unsigned PH_W     = $clog2(NUM_PHASES);

  typedef enum logic [2:0] {
    S_IDLE, S_SHUTTER, S_EXPOSE, S_XFER, S_LSHIFT, S_HREAD, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [VT_W-1:0]         vt_q, vt_d;
  logic [PH_W-1:0]         ph_q, ph_d;
  logic [CW-1:0]           ln_q, ln_d;
  logic [CW-1:0]           lines_done_q, lines_done_d;
  logic [2:0]              vbin_q, vbin_d;
  logic [23:0]             exp_q, exp_d;
  logic [CW-1:0]           pix_x_q, pix_x_d;
  logic [CW-1:0]           pix_y_q, pix_y_d;
  logic [NUM_PHASES-1:0]   xvt_q, xvt_d;
  logic                    rvt_q, rvt_d;
  logic                    thsub_q, thsub_d;
  logic                    hblank_q, hblank_d;
  logic                    pix_valid_q, pix_valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  // Lines binned into the current row and the resulting LSHIFT length.
  logic [CW-1:0]    rem_c;
  logic [CW-1:0]    n_c;
  logic [CNT_W-1:0] shift_len_c;
  logic [CNT_W-1:0] row_len_c;

  always_comb begin
    rem_c       = CW'(V_LINES) - lines_done_q;
    n_c         = (CW'(vbin_q) < rem_c) ? CW'(vbin_q) : rem_c;
    shift_len_c = CNT_W'(n_c) * CNT_W'(SHUT_LEN);
    row_len_c   = (shift_len_c > CNT_W'(H_BLANK)) ? shift_len_c : CNT_W'(H_BLANK);
  end

  // State register and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      vt_q         <= '0;
      ph_q         <= '0;
      ln_q         <= '0;
      lines_done_q <= '0;
      vbin_q       <= '0;
      exp_q        <= '0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      xvt_q        <= '0;
      rvt_q        <= 1'b0;
      thsub_q      <= 1'b0;
      hblank_q     <= 1'b1;
      pix_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      vt_q         <= vt_d;
      ph_q         <= ph_d;
      ln_q         <= ln_d;
      lines_done_q <= lines_done_d;
      vbin_q       <= vbin_d;
      exp_q        <= exp_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      xvt_q        <= xvt_d;
      rvt_q        <= rvt_d;
      thsub_q      <= thsub_d;
      hblank_q     <= hblank_d;
      pix_valid_q  <= pix_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next-state and counter logic; outputs are decoded from the next state so they register in step.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    vt_d         = vt_q;
    ph_d         = ph_q;
    ln_d         = ln_q;
    lines_done_d = lines_done_q;
    vbin_d       = vbin_q;
    exp_d        = exp_q;
    pix_x_d      = '0;
    pix_y_d      = pix_y_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          vbin_d       = (vbin == 3'd0) ? 3'd1 : vbin;
          exp_d        = exposure;
          lines_done_d = '0;
          pix_y_d      = '0;
          cnt_d        = '0;
          state_d      = S_SHUTTER;
        end
      end
      S_SHUTTER: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SHUT_LEN - 1)) begin
          cnt_d   = '0;
          state_d = (exp_q == 24'd0) ? S_XFER : S_EXPOSE;
        end
      end
      S_EXPOSE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(exp_q) - CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XFER_LEN - 1)) begin
          cnt_d   = '0;
          vt_d    = '0;
          ph_d    = '0;
          ln_d    = '0;
          state_d = S_LSHIFT;
        end
      end
      S_LSHIFT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Step through VT_WIDTH cycles per phase, NUM_PHASES phases per line, n lines.
        if (ln_q < n_c) begin
          if (vt_q == VT_W'(VT_WIDTH - 1)) begin
            vt_d = '0;
            if (ph_q == PH_W'(NUM_PHASES - 1)) begin
              ph_d = '0;
              ln_d = ln_q + CW'(1);
            end else begin
              ph_d = ph_q + PH_W'(1);
            end
          end else begin
            vt_d = vt_q + VT_W'(1);
          end
        end
        if (cnt_q == row_len_c - CNT_W'(1)) begin
          cnt_d        = '0;
          lines_done_d = lines_done_q + n_c;
          state_d      = S_HREAD;
        end
      end
      S_HREAD: begin
        pix_x_d = pix_x_q + CW'(1);
        if (pix_x_q == CW'(H_PIXELS - 1)) begin
          pix_x_d = '0;
          if (lines_done_q == CW'(V_LINES)) begin
            state_d = S_DONE;
          end else begin
            pix_y_d = pix_y_q + CW'(1);
            vt_d    = '0;
            ph_d    = '0;
            ln_d    = '0;
            cnt_d   = '0;
            state_d = S_LSHIFT;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    xvt_d       = '0;
    if (state_d == S_LSHIFT && ln_d < n_c) begin
      xvt_d = NUM_PHASES'(1) << ph_d;
    end
    rvt_d       = (state_d == S_XFER);
    thsub_d     = (state_d == S_SHUTTER);
    hblank_d    = (state_d != S_HREAD);
    pix_valid_d = (state_d == S_HREAD);
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
  end

  assign xvt       = xvt_q;
  assign rvt2      = rvt_q;
  assign rvt3      = rvt_q;
  assign thsub     = thsub_q;
  assign hblank    = hblank_q;
  assign pix_valid = pix_valid_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ccd_readout_seq.sv
// Scoreboard bench for ccd_readout_seq: expected output segments (vector + run length),
// pixel coordinates and frame lengths are queued when a frame is requested; a monitor
// on the falling clock edge pops and compares as the DUT produces them.
module tb_ccd_readout_seq;

  localparam int HP = 8;
  localparam int HB = 12;
  localparam int VL = 5;
  localparam int VT = 2;
  localparam int NP = 4;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  vbin;
  logic [23:0] exposure;
  logic [3:0]  xvt;
  logic        rvt2, rvt3, thsub, hblank, pix_valid, busy, done;
  logic [15:0] pix_x, pix_y;

  ccd_readout_seq #(
    .H_PIXELS(HP), .H_BLANK(HB), .V_LINES(VL), .VT_WIDTH(VT), .NUM_PHASES(NP), .CW(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .vbin(vbin), .exposure(exposure),
    .xvt(xvt), .rvt2(rvt2), .rvt3(rvt3), .thsub(thsub), .hblank(hblank),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [10:0] v; int len; } seg_t;
  typedef struct { int x; int y; } pix_t;

  seg_t seg_q[$];
  pix_t pix_q[$];
  int   len_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [10:0] mk(bit th, bit rv, logic [3:0] x, bit hb, bit pv, bit b, bit d);
    return {th, rv, rv, x, hb, pv, b, d};
  endfunction

  localparam logic [10:0] IDLE_V = 11'b000_0000_1000;

  function automatic logic [10:0] cur_vec();
    return {thsub, rvt2, rvt3, xvt, hblank, pix_valid, busy, done};
  endfunction

  task automatic push_seg(input logic [10:0] v, input int len);
    seg_t s;
    s.v = v;
    s.len = len;
    seg_q.push_back(s);
  endtask

  // Expected segment sequence of one frame with effective binning nb and exposure ex.
  task automatic push_frame(input int nb, input int ex);
    int lines;
    int y;
    int n;
    int sh;
    int l_row;
    pix_t p;
    push_seg(mk(1, 0, 4'd0, 1, 0, 1, 0), NP * VT);
    if (ex > 0) push_seg(mk(0, 0, 4'd0, 1, 0, 1, 0), ex);
    push_seg(mk(0, 1, 4'd0, 1, 0, 1, 0), 2 * VT);
    lines = 0;
    y = 0;
    while (lines < VL) begin
      n = (nb < VL - lines) ? nb : VL - lines;
      for (int l = 0; l < n; l++) begin
        for (int k = 0; k < NP; k++) begin
          push_seg(mk(0, 0, 4'(1 << k), 1, 0, 1, 0), VT);
        end
      end
      sh = n * NP * VT;
      l_row = (sh > HB) ? sh : HB;
      if (l_row > sh) push_seg(mk(0, 0, 4'd0, 1, 0, 1, 0), l_row - sh);
      push_seg(mk(0, 0, 4'd0, 0, 1, 1, 0), HP);
      for (int x = 0; x < HP; x++) begin
        p.x = x;
        p.y = y;
        pix_q.push_back(p);
      end
      lines += n;
      y++;
    end
    push_seg(mk(0, 0, 4'd0, 1, 0, 0, 1), 1);
  endtask

  // Monitor: run-length compare of the output vector, pixel coordinates and frame length.
  logic [10:0] run_v = IDLE_V;
  int          run_len = 0;
  int          busy_run = 0;

  task automatic close_run();
    seg_t e;
    if (seg_q.size() == 0) begin
      if (run_v != IDLE_V) begin
        total++;
        bad++;
        $display("FAIL seg_unexpected: got v=%b len=%0d need nothing", run_v, run_len);
      end
    end else if (run_v == IDLE_V && seg_q[0].v != IDLE_V) begin
      // idle gaps between frames are not timed unless an idle entry is queued
    end else begin
      e = seg_q.pop_front();
      total++;
      if (e.v !== run_v || e.len != run_len) begin
        bad++;
        $display("FAIL seg: got v=%b len=%0d need v=%b len=%0d", run_v, run_len, e.v, e.len);
      end
    end
  endtask

  always @(negedge clk) begin
    logic [10:0] v;
    pix_t p;
    int   exp_len;
    if (reset) begin
      run_v    = IDLE_V;
      run_len  = 0;
      busy_run = 0;
    end else begin
      v = cur_vec();
      if (run_len > 0 && v !== run_v) close_run();
      if (run_len > 0 && v === run_v) run_len++;
      else begin
        run_v   = v;
        run_len = 1;
      end

      total++;
      if (pix_valid) begin
        if (pix_q.size() == 0) begin
          bad++;
          $display("FAIL pix_unexpected: got x=%0d y=%0d need none", pix_x, pix_y);
        end else begin
          p = pix_q.pop_front();
          if (pix_x != 16'(p.x) || pix_y != 16'(p.y)) begin
            bad++;
            $display("FAIL pix: got x=%0d y=%0d need x=%0d y=%0d", pix_x, pix_y, p.x, p.y);
          end
        end
      end else if (pix_x != 16'd0) begin
        bad++;
        $display("FAIL pix_x_idle: got %0d need 0", pix_x);
      end

      if (busy) busy_run++;
      if (done) begin
        total++;
        if (len_q.size() == 0) begin
          bad++;
          $display("FAIL frame_len_unexpected: got %0d need none", busy_run + 1);
        end else begin
          exp_len = len_q.pop_front();
          if (busy_run + 1 != exp_len) begin
            bad++;
            $display("FAIL frame_len: got %0d need %0d", busy_run + 1, exp_len);
          end
        end
        busy_run = 0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] need);
    total++;
    if (got !== need) begin
      bad++;
      $display("FAIL %s: got %0h need %0h", name, got, need);
    end
  endtask

  task automatic pulse_start(input logic [2:0] vb, input logic [23:0] ex);
    @(negedge clk);
    vbin = vb;
    exposure = ex;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int i;
    i = 0;
    @(negedge clk);
    while (!done && i < limit) begin
      @(negedge clk);
      i++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done need done within %0d cycles", name, limit);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish need finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    reset = 1'b1;
    start = 1'b0;
    vbin = 3'd0;
    exposure = 24'd0;
    repeat (3) @(negedge clk);
    check("reset_state", {cur_vec(), pix_x, pix_y}, {IDLE_V, 16'd0, 16'd0});
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: basic frame
    push_frame(1, 3);
    len_q.push_back(116);
    pulse_start(3'd1, 24'd3);
    wait_done("basic", 300);
    check("basic_pix_y_end", pix_y, 16'd4);
    repeat (4) @(negedge clk);

    // 2: binning by 2
    push_frame(2, 5);
    len_q.push_back(86);
    pulse_start(3'd2, 24'd5);
    wait_done("bin2", 300);
    check("bin2_pix_y_end", pix_y, 16'd2);
    repeat (4) @(negedge clk);

    // 3: vbin=0, exposure=0
    push_frame(1, 0);
    len_q.push_back(113);
    pulse_start(3'd0, 24'd0);
    wait_done("edge", 300);
    repeat (4) @(negedge clk);

    // 4: start during HREAD of row 2 is ignored
    push_frame(1, 3);
    len_q.push_back(116);
    pulse_start(3'd1, 24'd3);
    i = 0;
    while (!(pix_valid && pix_y == 16'd2) && i < 200) begin
      @(negedge clk);
      i++;
    end
    check("row2_reached", {15'd0, pix_valid}, 16'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore", 300);
    repeat (150) @(negedge clk);
    check("no_second_frame_busy", {15'd0, busy}, 16'd0);

    // 5: start coincident with done ignored, accepted in the next idle cycle
    push_frame(4, 1);
    push_seg(IDLE_V, 1);
    push_frame(7, 2);
    len_q.push_back(74);
    len_q.push_back(63);
    pulse_start(3'd4, 24'd1);
    wait_done("restart_a", 300);
    vbin = 3'd7;
    exposure = 24'd2;
    start = 1'b1;
    @(negedge clk);
    check("restart_idle_busy", {15'd0, busy}, 16'd0);
    @(negedge clk);
    start = 1'b0;
    check("restart_thsub", {15'd0, thsub}, 16'd1);
    wait_done("restart_b", 300);
    check("restart_b_pix_y_end", pix_y, 16'd0);
    repeat (150) @(negedge clk);
    check("seg_q_empty", 64'(seg_q.size()), 64'd0);
    check("pix_q_empty", 64'(pix_q.size()), 64'd0);
    check("len_q_empty", 64'(len_q.size()), 64'd0);

    // 6: asynchronous reset during LSHIFT while xvt=0100
    push_frame(1, 0);
    len_q.push_back(113);
    pulse_start(3'd1, 24'd0);
    i = 0;
    while (xvt != 4'b0100 && i < 100) begin
      @(negedge clk);
      i++;
    end
    check("xvt_0100_reached", {12'd0, xvt}, 16'b0100);
    #1;
    reset = 1'b1;
    #1;
    check("async_reset", {cur_vec(), pix_x, pix_y}, {IDLE_V, 16'd0, 16'd0});
    seg_q.delete();
    pix_q.delete();
    len_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("post_reset_idle", {5'd0, cur_vec()}, {5'd0, IDLE_V});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ccd_readout_seq.md
Name: ccd_readout_seq

Overview:
- Parametrised CCD frame readout sequencer. It supersedes the fixed-geometry vertical/horizontal timing generator.
- Per frame it drives:
  - the electronic shutter (thsub);
  - the readout transfer gates (rvt2/rvt3);
  - an N-phase vertical line shift (xvt);
  - the horizontal blanking gate (hblank), which gates the H1/H2/RG clock buffers.
- New over the previous generation: programmable geometry, programmable exposure, vertical binning and a start/busy/done handshake.
- Runs in the 54 MHz pixel clock domain. Pixel coordinates are exported so the deserialised ADC data can be tagged downstream.

Parameters:
- H_PIXELS, 1024: pixel clocks per line with hblank low.
- H_BLANK, 64: minimum hblank cycles per line.
- V_LINES, 768: physical sensor lines to shift out per frame.
- VT_WIDTH, 8: cycles per vertical phase step.
- NUM_PHASES, 4: vertical clock phases, 2..8.
- CW, 16: width of the pix_x/pix_y counters; must hold max(H_PIXELS, V_LINES).

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle frame request.
- vbin  in  3  lines binned per output row; 0 is treated as 1; sampled on accepted start.
- exposure  in  24  cycles from end of shutter pulse to transfer; sampled on accepted start.
- xvt  out  NUM_PHASES  vertical shift clocks, one-hot during steps, else 0.
- rvt2  out  1  readout transfer gate, field 2.
- rvt3  out  1  readout transfer gate, field 3.
- thsub  out  1  substrate shutter pulse, active high.
- hblank  out  1  1 = horizontal clocks stopped.
- pix_valid  out  1  high during active pixel cycles.
- pix_x  out  CW  column index 0..H_PIXELS-1.
- pix_y  out  CW  output row index.
- busy  out  1  high from accepted start to done.
- done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset (async, immediate, from any state including mid-frame):
  - state=IDLE, hblank=1, all other outputs 0, all counters 0.
  - Nothing resumes after reset is released.
- All outputs are registered and change on clk rising edge only.
- IDLE:
  - hblank=1, busy=0.
  - start=1 → latch vbin (0→1) and exposure, busy=1 next cycle, go to SHUTTER.
- start is ignored whenever busy=1. No queueing.
- SHUTTER: thsub=1 for exactly NUM_PHASES*VT_WIDTH cycles → EXPOSE.
- EXPOSE:
  - Lasts exactly `exposure` cycles, all gates 0.
  - exposure=0 skips the state: XFER follows SHUTTER directly.
  - → XFER.
- XFER: rvt2=rvt3=1 for exactly 2*VT_WIDTH cycles → LSHIFT; pix_y=0.
- LSHIFT:
  - hblank=1.
  - Shifts n = min(vbin_l, V_LINES - lines_done) lines.
  - Each line is NUM_PHASES steps of VT_WIDTH cycles; during step k (0..NUM_PHASES-1), xvt = 1<<k.
  - After the shifts, xvt=0 and hblank is held until the state has lasted L = max(H_BLANK, n*NUM_PHASES*VT_WIDTH) cycles.
  - lines_done += n.
  - → HREAD.
- HREAD:
  - hblank=0 and pix_valid=1 for exactly H_PIXELS cycles.
  - pix_x counts 0..H_PIXELS-1 and is held at 0 outside HREAD.
  - At the end: if lines_done == V_LINES → DONE; else pix_y += 1 and → LSHIFT.
- Output rows per frame = ceil(V_LINES / vbin_l). The last row may bin fewer lines.
- DONE: done=1 for one cycle; busy falls in the same cycle; hblank=1; → IDLE.
- A start arriving in the DONE cycle is ignored. A start is accepted from the first IDLE cycle.
- Frame length = NUM_PHASES*VT_WIDTH + exposure + 2*VT_WIDTH + Σ(L_row + H_PIXELS) + 1 (DONE) cycles.

Test Plan:
Common bench parameters: H_PIXELS=8, H_BLANK=12, V_LINES=5, VT_WIDTH=2, NUM_PHASES=4.
1. Basic frame, vbin=1, exposure=3, start pulse:
   - thsub high 8 cycles, then 3 idle cycles, then rvt2/rvt3 high 4 cycles.
   - 5 rows, each 12 hblank + 8 pix_valid cycles.
   - done is one cycle; total 8+3+4+100+1=116 cycles; pix_y ends at 4.
2. Binning, vbin=2:
   - 3 rows.
   - LSHIFT lengths 16, 16, 12.
   - xvt shows 2, 2, 1 one-hot sequences 0001→0010→0100→1000, each step 2 cycles.
3. Edge settings, vbin=0 and exposure=0:
   - behaves as vbin=1;
   - rvt2 rises the cycle after thsub falls.
4. start pulsed during HREAD of row 2 → ignored: frame timing identical to scenario 1, and no second frame follows.
5. Restart timing:
   - start coincident with done → ignored.
   - start in the following IDLE cycle → new frame starts.
6. reset asserted mid-LSHIFT while xvt=0100 → all outputs 0 and hblank=1 immediately, asynchronously. After release, state stays IDLE until the next start.
